// File: rtl/cache_mem_responder.sv
// Fixed-latency main memory behind the L1 cache miss/write-back port.
// Define CACHE_MEM_STATS_EN to add saturating read/write response counters.
module cache_mem_responder #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 3,
    parameter int WR_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_write,
    output logic [DATA_W-1:0] resp_data,
`ifdef CACHE_MEM_STATS_EN
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
`endif
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] RD_CNT = 4'(RD_LATENCY - 1);
    localparam logic [3:0] WR_CNT = 4'(WR_LATENCY - 1);

    typedef logic [DATA_W-1:0] mem_t [DEPTH];
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Power-up image: each location holds the low byte of its own address
    function automatic mem_t mem_init();
        mem_t m;
        for (int a = 0; a < DEPTH; a++) m[a] = DATA_W'(a);
        return m;
    endfunction

    mem_t mem = mem_init();

    state_t            state, state_n;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic              accept;
    logic              fire;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_ready & req_valid;
    assign fire      = (state == WAIT) && (cnt == 4'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (req_valid) state_n = WAIT;
            WAIT:    if (cnt == 4'd0) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_data  <= '0;
        end else begin
            resp_valid <= fire;
            resp_write <= fire & write_q;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                write_q <= req_write;
                cnt     <= req_write ? WR_CNT : RD_CNT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (fire && !write_q) resp_data <= mem[addr_q];
        end
    end

    // Array has no reset: contents survive a reset pulse
    always_ff @(posedge clock) begin
        if (fire && write_q) mem[addr_q] <= wdata_q;
    end

`ifdef CACHE_MEM_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else if (fire) begin
            if (write_q && wr_count != 16'hFFFF)
                wr_count <= wr_count + 16'd1;
            if (!write_q && rd_count != 16'hFFFF)
                rd_count <= rd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: random traffic vs. an array model,
// plus a second instance with RD_LATENCY=1 / WR_LATENCY=15.
`timescale 1ns/1ps
module tb_cache_mem_responder;

    localparam int RD_LAT = 3;
    localparam int WR_LAT = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic       req_valid, req_ready, req_write;
    logic [9:0] req_addr;
    logic [7:0] req_wdata;
    logic       resp_valid, resp_write, busy;
    logic [7:0] resp_data;

    logic       s_req_valid, s_req_ready, s_req_write;
    logic [9:0] s_req_addr;
    logic [7:0] s_req_wdata;
    logic       s_resp_valid, s_resp_write, s_busy;
    logic [7:0] s_resp_data;

`ifdef CACHE_MEM_STATS_EN
    logic [15:0] rd_count, wr_count, s_rd_count, s_wr_count;
`endif

    cache_mem_responder #(
        .ADDR_W(10), .DATA_W(8),
        .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_write(resp_write),
        .resp_data(resp_data),
`ifdef CACHE_MEM_STATS_EN
        .rd_count(rd_count), .wr_count(wr_count),
`endif
        .busy(busy)
    );

    cache_mem_responder #(
        .ADDR_W(10), .DATA_W(8),
        .RD_LATENCY(1), .WR_LATENCY(15)
    ) u_sweep (
        .clock(clock), .reset(reset),
        .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_write(s_req_write), .req_addr(s_req_addr),
        .req_wdata(s_req_wdata),
        .resp_valid(s_resp_valid), .resp_write(s_resp_write),
        .resp_data(s_resp_data),
`ifdef CACHE_MEM_STATS_EN
        .rd_count(s_rd_count), .wr_count(s_wr_count),
`endif
        .busy(s_busy)
    );

    typedef struct {
        logic       wr;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [7:0] ref_mem [1024];
    int n_vec = 0;
    int n_miss = 0;
    int n_rd = 0;
    int n_wr = 0;
    int last_acc = -100;
    int last_lat = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_write", 32'(resp_write), 32'(e.wr));
                if (!e.wr) chk("resp_data", 32'(resp_data), 32'(e.data));
                chk("resp_latency", cyc, e.due);
                chk("busy_in_resp", {30'd0, busy, req_ready}, 32'd2);
                if (e.wr) n_wr++;
                else      n_rd++;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic wr, input logic [9:0] a,
                         input logic [7:0] d, input bit push,
                         input bit b2b);
        int n = 0;
        int acc;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        @(posedge clock);
        if (b2b) chk("b2b_spacing", acc - last_acc, last_lat + 2);
        last_acc = acc;
        last_lat = wr ? WR_LAT : RD_LAT;
        if (push) begin
            if (wr) begin
                ref_mem[a] = d;
                sb.push_back('{1'b1, 8'h00, acc + WR_LAT});
            end else begin
                sb.push_back('{1'b0, ref_mem[a], acc + RD_LAT});
            end
        end
        @(negedge clock);
        if (push) chk("busy_after_accept", {30'd0, busy, req_ready}, 32'd2);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) begin
            chk("drain_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    task automatic sw_req(input logic wr, input logic [9:0] a,
                          input logic [7:0] d, input int lat,
                          input logic [7:0] xd);
        int n = 0;
        int acc;
        s_req_valid = 1'b1;
        s_req_write = wr;
        s_req_addr  = a;
        s_req_wdata = d;
        while (!s_req_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        acc = cyc + 1;
        @(posedge clock);
        @(negedge clock);
        s_req_valid = 1'b0;
        n = 0;
        while (!s_resp_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("sw_resp_seen", 32'(s_resp_valid), 32'd1);
        chk("sw_latency", cyc - acc, lat);
        chk("sw_resp_write", 32'(s_resp_write), 32'(wr));
        if (!wr) chk("sw_resp_data", 32'(s_resp_data), 32'(xd));
        @(negedge clock);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_write"}, 32'(resp_write), 32'd0);
        chk({tag, "_resp_data"}, 32'(resp_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef CACHE_MEM_STATS_EN
        chk({tag, "_rd_count"}, 32'(rd_count), 32'd0);
        chk({tag, "_wr_count"}, 32'(wr_count), 32'd0);
`endif
    endtask

    initial begin
        bit        b2b;
        int        gap;
        logic      wr;
        logic [9:0] a;
        logic [7:0] d;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i);
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        s_req_valid = 0; s_req_write = 0; s_req_addr = 0; s_req_wdata = 0;

        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset_checks("reset");
        reset = 1'b0;
        @(negedge clock);

        issue(1'b0, 10'h010, 8'h00, 1'b1, 1'b0);
        wait_idle();
        issue(1'b1, 10'h01A, 8'h03, 1'b1, 1'b0);
        issue(1'b0, 10'h01A, 8'h00, 1'b1, 1'b1);
        wait_idle();
        issue(1'b0, 10'h014, 8'h00, 1'b1, 1'b0);
        issue(1'b0, 10'h006, 8'h00, 1'b1, 1'b1);
        wait_idle();

        // Write is in flight (WAIT) when reset hits; it must vanish
        issue(1'b1, 10'h020, 8'hAA, 1'b0, 1'b0);
        reset = 1'b1;
        n_rd = 0;
        n_wr = 0;
        @(negedge clock);
        reset_checks("mid_reset");
        reset = 1'b0;
        repeat (4) @(negedge clock);
        chk("no_resp_after_reset", 32'(sb.size()), 32'd0);
        issue(1'b0, 10'h020, 8'h00, 1'b1, 1'b0);
        wait_idle();

        sw_req(1'b0, 10'h3FF, 8'h00, 1, 8'hFF);
        sw_req(1'b1, 10'h155, 8'h5A, 15, 8'h00);
        sw_req(1'b0, 10'h155, 8'h00, 1, 8'h5A);

        gap = 1;
        for (int i = 0; i < 300; i++) begin
            b2b = (gap == 0);
            wr  = 1'($urandom % 2);
            if ($urandom % 4 == 0) a = 10'($urandom_range(0, 1023));
            else                   a = 10'($urandom_range(0, 15));
            d   = 8'($urandom);
            issue(wr, a, d, 1'b1, b2b);
            gap = int'($urandom % 3);
            repeat (gap) @(negedge clock);
        end
        wait_idle();

`ifdef CACHE_MEM_STATS_EN
        chk("rd_count", 32'(rd_count), n_rd);
        chk("wr_count", 32'(wr_count), n_wr);
        reset = 1'b1;
        @(negedge clock);
        chk("rd_count_reset", 32'(rd_count), 32'd0);
        chk("wr_count_reset", 32'(wr_count), 32'd0);
        reset = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Main-memory responder on the far side of the L1 cache's miss/write-back interface.
- Accepts single-byte line-fill reads (load) and write-back writes (wBack) from the cache controller over a valid/ready request channel.
- Models fixed access latency with a counter-driven FSM and returns data or a write acknowledge on a one-cycle response pulse.
- Address is {tag, index}, matching the cache's 8-bit tag and 2-bit index split.

Parameters:
- ADDR_W, 10, request address width; always {tag[7:0], index[1:0]}.
- DATA_W, 8, data width in bits; one byte per line.
- RD_LATENCY, 3, clock edges from the accepting edge to resp_valid for reads; legal range 1..15.
- WR_LATENCY, 2, clock edges from the accepting edge to resp_valid for writes; legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  cache presents a request.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = write-back (wBack), 0 = line fill (load).
- req_addr  in  ADDR_W  {tag, index}.
- req_wdata  in  DATA_W  write-back data; ignored for reads.
- resp_valid  out  1  one-cycle pulse: read data valid, or write committed.
- resp_write  out  1  qualifies resp_valid; 1 = write acknowledge, 0 = read data.
- resp_data  out  DATA_W  read data; holds its value until the next read response.
- busy  out  1  high in WAIT and RESP states.

Behaviour:
- Reset: state=IDLE, counter=0, req_ready=1, resp_valid=0, resp_write=0, resp_data=0, busy=0. Reset does not clear the memory array.
- Array: 2^ADDR_W x DATA_W. Elaboration-time contents are mem[a] = a[7:0].
- States and transitions:
  - IDLE: req_ready=1. On an edge with req_valid=1, latch addr, wdata and write, and load counter with LAT-1 (LAT = WR_LATENCY if write, else RD_LATENCY). Go to WAIT.
  - WAIT: decrement counter each edge. On an edge with counter==0, go to RESP. On that same edge:
    - write: commit mem[addr] <= wdata.
    - read: register resp_data <= mem[addr].
    - set resp_valid=1 and resp_write=latched write.
  - RESP: resp_valid high for exactly this one cycle. Next edge returns to IDLE and clears resp_valid.
- Timing:
  - resp_valid rises exactly LAT edges after the accepting edge.
  - Minimum spacing between accepted requests is LAT+2 cycles: one bubble in RESP, then re-accept in IDLE.
- Request inputs are sampled only at the accepting edge; changes during WAIT/RESP are ignored.
- req_valid held while req_ready=0 is not lost; it is accepted on the first IDLE edge.
- Read-after-write to the same address returns the new data, because the write commits before IDLE is re-entered.
- Counter width is 4 bits; no wrap, since it only counts down from LAT-1.
- Reset mid-operation: the FSM returns to IDLE immediately. An in-flight write is discarded (mem unchanged), no resp_valid is produced, and resp_data clears to 0.
- Address bits are used in full; there is no out-of-range case.

Optional Feature:
- Macro: CACHE_MEM_STATS_EN.
- Defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0].
  - Each increments on the edge that asserts resp_valid for its request type.
  - Both saturate at 16'hFFFF and clear to 0 on reset.
- Undefined:
  - Ports and counters are absent.
  - Core behaviour and timing are identical.

Test Plan:
- Reset, then read addr {8'h04,2'b00}=10'h010 -> req_ready=1 after reset; resp_valid pulses 3 edges after acceptance with resp_write=0 and resp_data=8'h10.
- Write addr {8'h06,2'b10}=10'h01A, data 8'h03 -> resp_valid pulses 2 edges after acceptance with resp_write=1; an immediate read of 10'h01A returns 8'h03.
- Back-to-back: req_valid held high across two reads (10'h014, 10'h006) -> second accepted exactly 5 cycles after the first; resp_data=8'h14, then 8'h06; req_ready=0 and busy=1 between.
- Reset asserted during WAIT of a write 8'hAA to 10'h020 -> resp_valid never pulses; state returns to IDLE; a subsequent read of 10'h020 returns 8'h20.
- Parameter sweep RD_LATENCY=1, WR_LATENCY=15 -> read response 1 edge after acceptance; write response 15 edges after acceptance.
- With CACHE_MEM_STATS_EN: 3 reads and 2 writes -> rd_count=3 and wr_count=2; reset clears both to 0.
